// File: rtl/r_release_scheduler.sv
// ---------------------------------------------------------------------------
// r_release_scheduler
//
// Chooses the source of each R-channel release slot for the ID-ordering
// datapath. A release slot goes either to the in-order response arriving
// directly from the slave side or to the next in-order entry of a row held in
// the response waiting memory. Direct arrivals win by default. Waiting rows
// are served round-robin. A starvation counter forces a waiting-memory grant
// after STARVE_LIMIT consecutive direct grants while some row is waiting.
// Only one release is in flight at a time.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   direct_valid/uid    in-order response on the direct path
//   direct_ready        direct response consumed (combinational on rel_ready)
//   wm_ready_vec        per-row "next-in-order entry is waiting" flags
//   release_idx_flat    per-row release pointers, row r at [r*COL_W +: COL_W]
//   wm_rd_en/uid        one-cycle read request to the waiting memory
//   wm_rd_valid         waiting-memory read data valid
//   rel_valid/uid/src   release offered downstream (src 0=direct, 1=memory)
//   rel_ready           downstream accepts the release
//   adv_en/adv_row      advance pulse for the released row (combinational)
//   busy                scheduler is not idle
// ---------------------------------------------------------------------------
module r_release_scheduler #(
    parameter int NUM_ROWS     = 16,
    parameter int NUM_COLS     = 16,
    parameter int ROW_W        = $clog2(NUM_ROWS),
    parameter int COL_W        = $clog2(NUM_COLS),
    parameter int UID_W        = ROW_W + COL_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      direct_valid,
    input  logic [UID_W-1:0]          direct_uid,
    output logic                      direct_ready,
    input  logic [NUM_ROWS-1:0]       wm_ready_vec,
    input  logic [NUM_ROWS*COL_W-1:0] release_idx_flat,
    output logic                      wm_rd_en,
    output logic [UID_W-1:0]          wm_rd_uid,
    input  logic                      wm_rd_valid,
    output logic                      rel_valid,
    output logic [UID_W-1:0]          rel_uid,
    output logic                      rel_src,
    input  logic                      rel_ready,
    output logic                      adv_en,
    output logic [ROW_W-1:0]          adv_row,
    output logic                      busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIR_HOLD = 2'd1,
        WM_RD    = 2'd2,
        WM_HOLD  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ROW_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic [UID_W-1:0]   rel_uid_r;
    logic               rel_src_r;
    logic               rel_valid_r;
    logic               wm_rd_en_r;
    logic [UID_W-1:0]   wm_rd_uid_r;
    logic               busy_r;

    logic               wm_any_s;
    logic               rr_found_s;
    logic [ROW_W-1:0]   rr_idx_s;
    logic [ROW_W-1:0]   rr_row_s;
    logic [UID_W-1:0]   rr_uid_s;
    logic               grant_dir_s;
    logic               grant_wm_s;
    logic               direct_ready_s;
    logic               adv_en_s;

    assign wm_any_s = |wm_ready_vec;

    // Round-robin search: first ready row after rr_ptr, wrapping, with rr_ptr
    // itself visited last so a lone ready row at rr_ptr is still granted.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = {ROW_W{1'b0}};
        rr_row_s   = {ROW_W{1'b0}};
        for (int i = 1; i <= NUM_ROWS; i++) begin
            rr_idx_s = ROW_W'((int'(rr_ptr_r) + i) % NUM_ROWS);
            if (!rr_found_s && wm_ready_vec[rr_idx_s]) begin
                rr_found_s = 1'b1;
                rr_row_s   = rr_idx_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        rr_uid_s = {rr_row_s, release_idx_flat[int'(rr_row_s)*COL_W +: COL_W]};
    end

    // Next-state decode, IDLE arbitration and the handshake pulses of the
    // HOLD states.
    always_comb begin
        state_nxt_s    = state_r;
        grant_dir_s    = 1'b0;
        grant_wm_s     = 1'b0;
        direct_ready_s = 1'b0;
        adv_en_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (wm_any_s && (starve_cnt_r == STARVE_MAX)) begin
                    grant_wm_s  = 1'b1;
                    state_nxt_s = WM_RD;
                end else if (direct_valid) begin
                    grant_dir_s = 1'b1;
                    state_nxt_s = DIR_HOLD;
                end else if (wm_any_s) begin
                    grant_wm_s  = 1'b1;
                    state_nxt_s = WM_RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIR_HOLD: begin
                if (rel_ready) begin
                    direct_ready_s = 1'b1;
                    adv_en_s       = 1'b1;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s = DIR_HOLD;
                end
            end
            WM_RD: begin
                // The read-request cycle itself cannot carry the answer, so a
                // valid left over from the previous read is ignored there.
                if (wm_rd_valid && !wm_rd_en_r) begin
                    state_nxt_s = WM_HOLD;
                end else begin
                    state_nxt_s = WM_RD;
                end
            end
            WM_HOLD: begin
                if (rel_ready) begin
                    adv_en_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WM_HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus grant bookkeeping (rr pointer, starvation count,
    // captured release uid and source).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= ROW_W'(NUM_ROWS - 1);
            starve_cnt_r <= {CNT_W{1'b0}};
            rel_uid_r    <= {UID_W{1'b0}};
            rel_src_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_dir_s) begin
                rel_uid_r <= direct_uid;
                rel_src_r <= 1'b0;
                if (!wm_any_s) begin
                    starve_cnt_r <= {CNT_W{1'b0}};
                end else if (starve_cnt_r != STARVE_MAX) begin
                    starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                end else begin
                    starve_cnt_r <= STARVE_MAX;
                end
            end else if (grant_wm_s) begin
                rel_uid_r    <= rr_uid_s;
                rel_src_r    <= 1'b1;
                rr_ptr_r     <= rr_row_s;
                starve_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Registered outputs derived from the next state, so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_valid_r <= 1'b0;
            wm_rd_en_r  <= 1'b0;
            wm_rd_uid_r <= {UID_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            rel_valid_r <= (state_nxt_s == DIR_HOLD) || (state_nxt_s == WM_HOLD);
            wm_rd_en_r  <= grant_wm_s;
            wm_rd_uid_r <= grant_wm_s ? rr_uid_s : {UID_W{1'b0}};
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign rel_valid    = rel_valid_r;
    assign rel_uid      = rel_uid_r;
    assign rel_src      = rel_src_r;
    assign wm_rd_en     = wm_rd_en_r;
    assign wm_rd_uid    = wm_rd_uid_r;
    assign busy         = busy_r;
    assign direct_ready = direct_ready_s;
    assign adv_en       = adv_en_s;
    assign adv_row      = rel_uid_r[UID_W-1:COL_W];

endmodule

// File: tb/tb_r_release_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for r_release_scheduler (default parameters: 16x16, uid 8 bits,
// STARVE_LIMIT 4). Directed stimulus pushes the expected releases
// ({src, uid}) into a queue; a monitor pops and compares on every accepted
// release. Timing-specific points are checked directly in the stimulus.
// ---------------------------------------------------------------------------
module tb_r_release_scheduler;

    logic        clk;
    logic        rst;
    logic        direct_valid;
    logic [7:0]  direct_uid;
    logic        direct_ready;
    logic [15:0] wm_ready_vec;
    logic [63:0] release_idx_flat;
    logic        wm_rd_en;
    logic [7:0]  wm_rd_uid;
    logic        wm_rd_valid;
    logic        rel_valid;
    logic [7:0]  rel_uid;
    logic        rel_src;
    logic        rel_ready;
    logic        adv_en;
    logic [3:0]  adv_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rel_cnt = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    logic [8:0] exp_q[$];

    // monitor-private state
    int         rd_cnt = 0;
    logic [7:0] rd_uid_seen = 8'h00;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_uid = 8'h00;
    logic       prev_src = 1'b0;

    r_release_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .direct_valid     (direct_valid),
        .direct_uid       (direct_uid),
        .direct_ready     (direct_ready),
        .wm_ready_vec     (wm_ready_vec),
        .release_idx_flat (release_idx_flat),
        .wm_rd_en         (wm_rd_en),
        .wm_rd_uid        (wm_rd_uid),
        .wm_rd_valid      (wm_rd_valid),
        .rel_valid        (rel_valid),
        .rel_uid          (rel_uid),
        .rel_src          (rel_src),
        .rel_ready        (rel_ready),
        .adv_en           (adv_en),
        .adv_row          (adv_row),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input int row, input logic [3:0] val);
        release_idx_flat[row*4 +: 4] = val;
    endtask

    task automatic push(input logic src, input logic [7:0] uid);
        exp_q.push_back({src, uid});
    endtask

    task automatic wait_rel(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rel_cnt < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(rel_cnt >= n), 32'd1);
    endtask

    task automatic wait_rel_valid(input int budget, input string name);
        int k;
        k = 0;
        while (!rel_valid && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(rel_valid), 32'd1);
    endtask

    // Waiting-memory model: answers mem_lat cycles after the read request and
    // keeps valid high until the next request.
    initial begin
        wm_rd_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                wm_rd_valid = 1'b0;
                mem_cnt = 0;
            end else if (wm_rd_en) begin
                wm_rd_valid = 1'b0;
                mem_cnt = mem_lat;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) wm_rd_valid = 1'b1;
            end
        end
    end

    // Monitor: compares every accepted release against the scoreboard queue.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_cnt = 0;
                prev_hold = 1'b0;
            end else begin
                if (wm_rd_en) begin
                    rd_cnt++;
                    rd_uid_seen = wm_rd_uid;
                end
                if (prev_hold && rel_valid) begin
                    chk("hold_stable", {23'd0, rel_src, rel_uid}, {23'd0, prev_src, prev_uid});
                end
                if (rel_valid && rel_ready) begin
                    chk("rel_adv_en", 32'(adv_en), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_release", {24'd0, rel_uid}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rel_uid", 32'(rel_uid), 32'(e[7:0]));
                        chk("rel_src", 32'(rel_src), 32'(e[8]));
                        chk("adv_row", 32'(adv_row), 32'(e[7:4]));
                        chk("direct_ready", 32'(direct_ready), 32'(!e[8]));
                        chk("rd_en_pulses", 32'(rd_cnt), e[8] ? 32'd1 : 32'd0);
                        if (e[8]) chk("wm_rd_uid", 32'(rd_uid_seen), 32'(e[7:0]));
                    end
                    rd_cnt = 0;
                    rel_cnt++;
                end else begin
                    chk("idle_pulses", {30'd0, adv_en, direct_ready}, 32'd0);
                end
                prev_hold = rel_valid && !rel_ready;
                prev_uid  = rel_uid;
                prev_src  = rel_src;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic seen;
        rst = 1'b0;
        direct_valid = 1'b0;
        direct_uid = 8'h00;
        wm_ready_vec = 16'h0000;
        release_idx_flat = 64'h0;
        rel_ready = 1'b1;

        // reset state
        #23;
        chk("reset_outputs",
            {12'd0, direct_ready, wm_rd_en, wm_rd_uid, rel_valid, rel_uid, rel_src, adv_en, adv_row, busy},
            32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // direct only
        direct_valid = 1'b1;
        direct_uid = 8'h23;
        push(1'b0, 8'h23);
        step();
        chk("dir_rel_valid_t1", 32'(rel_valid), 32'd1);
        chk("dir_rel_uid_t1", 32'(rel_uid), 32'h23);
        chk("dir_rel_src_t1", 32'(rel_src), 32'd0);
        chk("dir_ready_adv_t1", {30'd0, direct_ready, adv_en}, 32'd3);
        chk("dir_adv_row_t1", 32'(adv_row), 32'd2);
        direct_valid = 1'b0;
        step();
        chk("dir_busy_t2", {30'd0, busy, rel_valid}, 32'd0);

        // round-robin with wrap
        set_idx(0, 4'h1);
        set_idx(3, 4'h4);
        set_idx(5, 4'h7);
        wm_ready_vec = 16'h0029;
        push(1'b1, 8'h01);
        push(1'b1, 8'h34);
        push(1'b1, 8'h57);
        push(1'b1, 8'h01);
        wait_rel(5, 60, "rr_done");
        wm_ready_vec = 16'h0000;

        // starvation limit
        set_idx(7, 4'h9);
        direct_uid = 8'h11;
        direct_valid = 1'b1;
        wm_ready_vec = 16'h0080;
        for (int i = 0; i < 4; i++) push(1'b0, 8'h11);
        push(1'b1, 8'h79);
        push(1'b0, 8'h11);
        wait_rel(11, 80, "starve_done");
        direct_valid = 1'b0;
        wm_ready_vec = 16'h0000;

        // backpressure in WM_HOLD (search from row 7 wraps to row 2)
        rel_ready = 1'b0;
        set_idx(2, 4'hA);
        wm_ready_vec = 16'h0004;
        push(1'b1, 8'h2A);
        wait_rel_valid(10, "bp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {19'd0, rel_valid, rel_src, rel_uid, adv_en, direct_ready, busy},
                {19'd0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1});
            step();
        end
        rel_ready = 1'b1;
        step();
        wm_ready_vec = 16'h0000;
        chk("bp_adv_after", 32'(adv_en), 32'd0);
        wait_rel(12, 5, "bp_done");

        // slow memory; rr_ptr is row 2 and is the only ready row
        mem_lat = 3;
        set_idx(2, 4'hB);
        wm_ready_vec = 16'h0004;
        push(1'b1, 8'h2B);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            seen = wm_rd_en;
            k++;
        end
        chk("slow_rd_en_seen", 32'(seen), 32'd1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            seen = wm_rd_valid;
            if (!seen) chk("slow_wait", {30'd0, rel_valid, busy}, 32'd1);
            k++;
        end
        chk("slow_rd_valid_seen", 32'(seen), 32'd1);
        chk("slow_no_early_valid", 32'(rel_valid), 32'd0);
        @(negedge clk);
        chk("slow_rel_valid_next", 32'(rel_valid), 32'd1);
        @(posedge clk);
        #1;
        wm_ready_vec = 16'h0000;
        mem_lat = 1;
        wait_rel(13, 5, "slow_done");

        // reset in the middle of WM_HOLD
        rel_ready = 1'b0;
        set_idx(4, 4'h3);
        wm_ready_vec = 16'h0010;
        wait_rel_valid(10, "rst_hold_reached");
        #2;
        rst = 1'b0;
        rel_ready = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {12'd0, direct_ready, wm_rd_en, wm_rd_uid, rel_valid, rel_uid, rel_src, adv_en, adv_row, busy},
            32'd0);
        set_idx(0, 4'h5);
        set_idx(15, 4'hC);
        wm_ready_vec = 16'h8001;
        push(1'b1, 8'h05);
        push(1'b1, 8'hFC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_rel(15, 30, "post_rst_done");
        wm_ready_vec = 16'h0000;
        step();
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_rel_count", 32'(rel_cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
